mem_access_unit: RTL

//   MEM-stage initiator for the word-addressed data memory. Takes load/store

---
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the word-addressed data memory.
// Converts byte/half/word loads and stores into word transactions on a
// req/ready port, using read-modify-write for sub-word stores, and stalls
// the pipeline until each access retires.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_rd,
  input  logic        op_wr,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  size_e       size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        load_q, load_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fault_q, fault_d;

  logic        op_valid;
  logic        op_illegal;
  logic        op_legal;
  logic [4:0]  lane_shamt;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] rmw_merged;

  // Classify the incoming op: any alignment, size, range or rd&wr violation faults.
  always_comb begin
    op_valid   = op_rd | op_wr;
    op_illegal = (op_rd & op_wr)
               | (op_size == SZ_ILL)
               | ((op_size == SZ_HALF) & op_addr[0])
               | ((op_size == SZ_WORD) & (|op_addr[1:0]))
               | (op_addr >= ADDR_LIMIT);
    op_legal   = op_valid & ~op_illegal;
  end

  // Lane extraction and extension for loads, lane merge for sub-word stores.
  always_comb begin
    lane_shamt = {addr_q[1:0], 3'b000};
    rd_shift   = mem_rdata >> lane_shamt;
    case (size_q)
      SZ_BYTE: rd_ext = unsigned_q ? {24'h0, rd_shift[7:0]}
                                   : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rd_ext = unsigned_q ? {16'h0, rd_shift[15:0]}
                                   : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
    if (size_q == SZ_HALF) begin
      lane_mask = 32'h0000_FFFF << lane_shamt;
      lane_data = {16'h0, mem_wdata_q[15:0]} << lane_shamt;
    end else begin
      lane_mask = 32'h0000_00FF << lane_shamt;
      lane_data = {24'h0, mem_wdata_q[7:0]} << lane_shamt;
    end
    rmw_merged = (mem_rdata & ~lane_mask) | lane_data;
  end

  // Next-state, operand latching and per-state outputs.
  // mem_wdata_q holds the raw store data until the RMW read returns, then the merged word.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    load_d      = load_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    load_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_legal) begin
          stall      = 1'b1;
          addr_d     = op_addr;
          size_d     = size_e'(op_size);
          unsigned_d = op_unsigned;
          load_d     = op_rd;
          if (op_rd) begin
            state_d = RD;
          end else begin
            mem_wdata_d = op_wdata;
            state_d     = (op_size == SZ_WORD) ? WR : RMW_RD;
          end
        end else if (op_valid) begin
          fault_d = 1'b1;
        end
      end
      RD: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          load_data_d = rd_ext;
          state_d     = DONE;
        end
      end
      RMW_RD: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          mem_wdata_d = rmw_merged;
          state_d     = WR;
        end
      end
      WR: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        load_valid = load_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      load_q      <= 1'b0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      load_q      <= load_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_waddr = addr_q[31:2];
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
  assign fault     = fault_q;

endmodule
